// File: rtl/ram_ctrl_pkg.sv
// Shared state encoding and bus constants for the SPI RAM command back end.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} packer_state_e;

  localparam logic [3:0]  BE_FULL    = 4'hF;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: head valid whenever !empty, zero added latency.
// A full FIFO still accepts a push in a cycle where the head is popped.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: head is only looked at while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ram_write_packer.sv
// Turns a write header plus payload stream into sequential single-word bus writes,
// one outstanding at a time; pack_done pulses the cycle after the last response.
module ram_write_packer
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_sys,
  input  logic                  rst_sys_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [CNT_WIDTH-1:0]  cmd_size,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic                  mem_err_i,
  output logic                  pack_done,
  output logic                  pack_err,
  output logic                  busy
);

  packer_state_e         state;
  packer_state_e         state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  size_q;
  logic [CNT_WIDTH-1:0]  remain_q;
  logic [CNT_WIDTH-1:0]  pushed_q;
  logic                  err_q;
  logic                  in_burst;
  logic                  cmd_fire;
  logic                  wr_fire;
  logic                  gnt_fire;
  logic                  rsp_fire;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  assign in_burst  = (state == ISSUE) || (state == WAIT_RSP);
  // Held low during reset so every output reads 0 while rst_sys_n is asserted.
  assign cmd_ready = rst_sys_n && (state == IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wr_ready  = in_burst && !fifo_full && (pushed_q != size_q);
  assign wr_fire   = wr_valid && wr_ready;

  assign mem_req_o   = (state == ISSUE) && !fifo_empty;
  assign mem_we_o    = mem_req_o;
  assign mem_be_o    = mem_req_o ? BE_FULL : 4'h0;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = mem_req_o ? fifo_head : '0;
  assign gnt_fire    = mem_req_o && mem_gnt_i;
  assign rsp_fire    = (state == WAIT_RSP) && mem_rvalid_i;

  assign pack_done = (state == DONE);
  assign pack_err  = pack_done && err_q;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          if ((cmd_addr[1:0] != 2'b00) || (cmd_size == '0)) state_nxt = DONE;
          else                                              state_nxt = ISSUE;
        end
      end
      ISSUE:    if (gnt_fire) state_nxt = WAIT_RSP;
      WAIT_RSP: begin
        if (rsp_fire) state_nxt = (remain_q == CNT_WIDTH'(1)) ? DONE : ISSUE;
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      remain_q <= '0;
      pushed_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cmd_fire) begin
        addr_q   <= cmd_addr;
        size_q   <= cmd_size;
        remain_q <= cmd_size;
        pushed_q <= '0;
        err_q    <= (cmd_addr[1:0] != 2'b00);
      end
      if (wr_fire) pushed_q <= pushed_q + CNT_WIDTH'(1);
      // Bus errors are sticky but never cut the burst short.
      if (rsp_fire) begin
        err_q    <= err_q | mem_err_i;
        addr_q   <= addr_q + ADDR_WIDTH'(WORD_BYTES);
        remain_q <= remain_q - CNT_WIDTH'(1);
      end
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk_sys),
    .rst_n     (rst_sys_n),
    .flush     (cmd_fire),
    .push      (wr_fire),
    .push_data (wr_data),
    .pop       (gnt_fire),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ram_write_packer.sv
// Directed bench for ram_write_packer: a queue-based burst model checked every cycle,
// plus literal expectations per scenario.
module tb_ram_write_packer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 32;

  logic          clk_sys = 1'b0;
  logic          rst_sys_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [CW-1:0] cmd_size = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          mem_req_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_we_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_rvalid_i = 1'b0;
  logic          mem_err_i = 1'b0;
  logic          pack_done;
  logic          pack_err;
  logic          busy;

  ram_write_packer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_size     (cmd_size),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_err_i    (mem_err_i),
    .pack_done    (pack_done),
    .pack_err     (pack_err),
    .busy         (busy)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Stimulus agent state
  bit          cmd_pend = 0;
  logic [31:0] nxt_addr = '0;
  logic [31:0] nxt_size = '0;
  logic [31:0] wr_q[$];
  bit          rsp_due = 0;
  int          gnt_hold = 0;
  bit [7:0]    err_mask = '0;
  int          rsp_idx = 0;

  // Burst model: queue of payload words plus push/grant/ack counts
  bit          m_live = 0, m_out = 0, m_done_now = 0, m_err = 0;
  bit          m_nxt_done, m_exp_req, m_exp_wr;
  logic [31:0] m_base = '0, m_size = '0, m_exp_addr;
  int unsigned m_pushed = 0, m_granted = 0, m_acked = 0;
  logic [31:0] m_q[$];

  // Observation log for literal checks
  int          cyc = 0, done_cnt = 0, done_cyc = 0, rv_cyc = 0, req_cnt = 0;
  bit          last_err = 0;
  logic [31:0] log_a[$], log_d[$];
  logic [3:0]  log_be[$];

  logic [31:0] t2_d[6] = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16};
  logic [31:0] t2_a[6] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h1014};

  initial begin : compare
    forever begin
      @(negedge clk_sys);
      #2;
      cyc++;
      if (!rst_sys_n) begin
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_be", mem_be_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_pack_done", pack_done, 0);
        chk("rst_pack_err", pack_err, 0);
        chk("rst_busy", busy, 0);
        m_live = 0; m_out = 0; m_done_now = 0; m_err = 0;
        m_q.delete();
      end else begin
        m_exp_req  = m_live && !m_out && (m_q.size() != 0);
        m_exp_wr   = m_live && (m_q.size() < DEPTH) && (m_pushed < m_size);
        m_exp_addr = m_base + 32'(4 * m_granted);
        chk("cmd_ready", cmd_ready, !(m_live || m_done_now));
        chk("busy", busy, m_live || m_done_now);
        chk("pack_done", pack_done, m_done_now);
        chk("pack_err", pack_err, m_done_now && m_err);
        chk("wr_ready", wr_ready, m_exp_wr);
        chk("mem_req", mem_req_o, m_exp_req);
        chk("mem_we", mem_we_o, m_exp_req);
        chk("mem_be", mem_be_o, m_exp_req ? 4'hF : 4'h0);
        if (m_exp_req) begin
          chk("mem_addr", mem_addr_o, m_exp_addr);
          chk("mem_wdata", mem_wdata_o, m_q[0]);
        end

        if (pack_done) begin done_cnt++; done_cyc = cyc; last_err = pack_err; end
        if (mem_req_o) req_cnt++;
        if (mem_req_o && mem_gnt_i) begin
          log_a.push_back(mem_addr_o);
          log_d.push_back(mem_wdata_o);
          log_be.push_back(mem_be_o);
        end

        m_nxt_done = 0;
        if (cmd_valid && cmd_ready) begin
          m_base = cmd_addr; m_size = cmd_size;
          m_pushed = 0; m_granted = 0; m_acked = 0; m_out = 0;
          m_q.delete();
          m_err = (cmd_addr[1:0] != 2'b00);
          if (m_err || cmd_size == 0) m_nxt_done = 1;
          else m_live = 1;
        end else if (m_live) begin
          if (wr_valid && wr_ready) begin m_q.push_back(wr_data); m_pushed++; end
          if (m_exp_req && mem_gnt_i) begin
            void'(m_q.pop_front());
            m_granted++;
            m_out = 1;
          end else if (m_out && mem_rvalid_i) begin
            m_err = m_err | mem_err_i;
            m_acked++;
            m_out = 0;
            rv_cyc = cyc;
            if (m_acked == m_size) begin m_live = 0; m_nxt_done = 1; end
          end
        end
        m_done_now = m_nxt_done;
      end
    end
  end

  task automatic tick();
    @(negedge clk_sys);
    cmd_valid    = cmd_pend;
    cmd_addr     = nxt_addr;
    cmd_size     = nxt_size;
    wr_valid     = (wr_q.size() != 0);
    wr_data      = wr_valid ? wr_q[0] : '0;
    mem_gnt_i    = (gnt_hold == 0);
    mem_rvalid_i = rsp_due;
    mem_err_i    = rsp_due && err_mask[rsp_idx];
    #1;
    if (cmd_valid && cmd_ready) cmd_pend = 0;
    if (wr_valid && wr_ready) void'(wr_q.pop_front());
    if (mem_rvalid_i) rsp_idx++;
    rsp_due = mem_req_o && mem_gnt_i;
    if (gnt_hold > 0) gnt_hold--;
  endtask

  task automatic start_cmd(input logic [31:0] a, input logic [31:0] s);
    log_a.delete(); log_d.delete(); log_be.delete();
    rsp_idx  = 0;
    err_mask = '0;
    nxt_addr = a;
    nxt_size = s;
    cmd_pend = 1;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin tick(); n++; end
    chk({name, "_done_seen"}, done_cnt - d0, 1);
    tick(); tick();
    chk({name, "_single_pulse"}, done_cnt - d0, 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int d0;
    int r0;
    int n;
    #1 rst_sys_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    rst_sys_n = 1'b1;
    tick(); tick();
    chk("post_reset_cmd_ready", cmd_ready, 1);
    chk("post_reset_no_done", done_cnt, 0);

    // Basic 3-word burst, grant immediate, response next cycle
    d0 = done_cnt;
    start_cmd(32'h1000, 3);
    wr_q = '{32'hA, 32'hB, 32'hC};
    wait_done(d0, 60, "t1");
    chk("t1_nwrites", log_a.size(), 3);
    chk("t1_a0", log_a[0], 32'h1000);
    chk("t1_a1", log_a[1], 32'h1004);
    chk("t1_a2", log_a[2], 32'h1008);
    chk("t1_d0", log_d[0], 32'hA);
    chk("t1_d1", log_d[1], 32'hB);
    chk("t1_d2", log_d[2], 32'hC);
    chk("t1_be2", log_be[2], 4'hF);
    chk("t1_done_after_last_rsp", done_cyc - rv_cyc, 1);
    chk("t1_pack_err", last_err, 0);

    // Backpressure: grant withheld while the FIFO fills
    d0 = done_cnt;
    start_cmd(32'h1000, 6);
    wr_q = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16};
    gnt_hold = 12;
    repeat (11) tick();
    chk("t2_words_left", wr_q.size(), 2);
    chk("t2_wr_ready_full", wr_ready, 0);
    chk("t2_req_held", mem_req_o, 1);
    chk("t2_addr_held", mem_addr_o, 32'h1000);
    chk("t2_wdata_held", mem_wdata_o, 32'h11);
    chk("t2_no_write_yet", log_a.size(), 0);
    wait_done(d0, 80, "t2");
    chk("t2_nwrites", log_a.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t2_addr", log_a[i], t2_a[i]);
      chk("t2_data", log_d[i], t2_d[i]);
    end

    // Zero size: done one cycle after header, no request
    r0 = req_cnt;
    start_cmd(32'h2000, 0);
    tick(); tick();
    chk("t3_zero_done", pack_done, 1);
    chk("t3_zero_err", pack_err, 0);
    tick();
    chk("t3_zero_no_req", req_cnt - r0, 0);

    // Misaligned: error done, payload untouched
    start_cmd(32'h1002, 2);
    wr_q = '{32'h1, 32'h2};
    tick(); tick();
    chk("t3_mis_done", pack_done, 1);
    chk("t3_mis_err", pack_err, 1);
    tick();
    chk("t3_mis_no_req", req_cnt - r0, 0);
    chk("t3_mis_words_kept", wr_q.size(), 2);
    wr_q.delete();

    // Bus error on first response plus address wrap
    d0 = done_cnt;
    start_cmd(32'hFFFF_FFFC, 2);
    err_mask = 8'b0000_0001;
    wr_q = '{32'h55, 32'h66};
    wait_done(d0, 60, "t4");
    chk("t4_nwrites", log_a.size(), 2);
    chk("t4_a0", log_a[0], 32'hFFFF_FFFC);
    chk("t4_a1_wrap", log_a[1], 32'h0000_0000);
    chk("t4_d1", log_d[1], 32'h66);
    chk("t4_pack_err", last_err, 1);

    // Header during WAIT_RSP and a surplus payload word
    d0 = done_cnt;
    start_cmd(32'h3000, 3);
    wr_q = '{32'h71, 32'h72, 32'h73, 32'h74};
    n = 0;
    while (!rsp_due && n < 20) begin tick(); n++; end
    chk("t5_first_grant", rsp_due, 1);
    nxt_addr = 32'h4000;
    nxt_size = 32'd1;
    cmd_pend = 1;
    tick();
    chk("t5_cmd_ready_busy", cmd_ready, 0);
    chk("t5_hdr_not_taken", cmd_pend, 1);
    cmd_pend = 0;
    wait_done(d0, 60, "t5");
    chk("t5_nwrites", log_a.size(), 3);
    chk("t5_d2", log_d[2], 32'h73);
    chk("t5_extra_not_taken", wr_q.size(), 1);
    chk("t5_wr_ready_idle", wr_ready, 0);
    wr_q.delete();

    // Reset after the first of three grants
    start_cmd(32'h5000, 3);
    wr_q = '{32'h81, 32'h82, 32'h83};
    n = 0;
    while (!rsp_due && n < 20) begin tick(); n++; end
    chk("t6_first_grant", rsp_due, 1);
    @(negedge clk_sys);
    #1;
    rst_sys_n = 1'b0;
    cmd_pend = 0; rsp_due = 0; wr_q.delete();
    cmd_valid = 0; wr_valid = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0;
    #2;
    chk("t6_req_low", mem_req_o, 0);
    chk("t6_busy_low", busy, 0);
    chk("t6_addr_zero", mem_addr_o, 0);
    chk("t6_cmd_ready_low", cmd_ready, 0);
    d0 = done_cnt;
    repeat (2) @(negedge clk_sys);
    rst_sys_n = 1'b1;
    tick(); tick(); tick();
    chk("t6_cmd_ready_after", cmd_ready, 1);
    chk("t6_no_done", done_cnt - d0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
